regfile_dump_reader: RTL and testbench

Debug readout engine that acts as the reader on the register file's A1/RD1 read port. On a START pulse it sweeps a register index range, one index per read. It absorbs the register file's registered read latency. Each word is presented on a valid/ready output stream as {index, data}, for consumption by the UART/display debug path. The block sits beside the datapath and takes over read port 1 only when the top level muxes A1 to it, i.e. while BUSY is high.

---
 rtl/regfile_dump_reader_pkg.sv | 10 +
 rtl/regfile_dump_reader_if.sv | 13 +
 rtl/regfile_read_sequencer.sv | 40 ++++
 rtl/regfile_dump_reader.sv | 67 ++++++
 tb/tb_regfile_dump_reader.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// regfile_dump_reader_pkg: register-file constants and dump reader state encoding,
// shared with the register file and other read-port masters.
package regfile_dump_reader_pkg;
   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 16;
   localparam int PC_IDX     = 15;
   localparam int RD_LATENCY = 2;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT} state_t;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: valid/ready stream carrying {index, data, last} dump words.
interface regfile_dump_reader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] index;
   logic [DATA_W-1:0] data;
   logic              last;
   modport master (output valid, index, data, last, input ready);
   modport slave (input valid, index, data, last, output ready);
endinterface

// File: rtl/regfile_read_sequencer.sv
// regfile_read_sequencer: read address register with modulo increment, read-latency
// countdown and last-index compare for sweeping the register file read port.
module regfile_read_sequencer
   import regfile_dump_reader_pkg::*;
#(
   parameter int ADDR_W       = REG_ADDR_W,
   parameter int READ_LATENCY = RD_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] first_idx,
   input  logic [ADDR_W-1:0] last_idx,
   output logic [ADDR_W-1:0] a1,
   output logic              capture_now,
   output logic              at_last
);
   localparam int CNT_W = $clog2(READ_LATENCY + 1);
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] last_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1     <= '0;
         last_q <= '0;
         cnt    <= '0;
      end else begin
         if (load) begin
            a1     <= first_idx;
            last_q <= last_idx;
         end else if (advance) begin
            a1 <= a1 + ADDR_W'(1);
         end
         cnt <= (load || advance) ? CNT_W'(READ_LATENCY) : (|cnt) ? cnt - CNT_W'(1) : cnt;
      end
   end
   // RD1 for the current A1 is valid on the edge where the countdown reaches 1
   assign capture_now = cnt == CNT_W'(1);
   assign at_last     = a1 == last_q;
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: sweeps a register index range over read port 1 and streams
// each captured word out as {index, data, last} on a valid/ready interface.
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int ADDR_W       = REG_ADDR_W,
   parameter int DATA_W       = REG_DATA_W,
   parameter int READ_LATENCY = RD_LATENCY
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       first_idx,
   input  logic [ADDR_W-1:0]       last_idx,
   output logic [ADDR_W-1:0]       a1,
   input  logic [DATA_W-1:0]       rd1,
   regfile_dump_reader_if.master   out,
   output logic                    busy,
   output logic                    done
);
   state_t state, state_next;
   logic   load, capture, hs, advance, finish, capture_now, at_last;
   regfile_read_sequencer #(.ADDR_W(ADDR_W), .READ_LATENCY(READ_LATENCY)) u_seq (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .advance     (advance),
      .first_idx   (first_idx),
      .last_idx    (last_idx),
      .a1          (a1),
      .capture_now (capture_now),
      .at_last     (at_last)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end
   always_comb begin
      load       = state == S_IDLE && start;
      capture    = state == S_WAIT && capture_now;
      hs         = state == S_PRESENT && out.valid && out.ready;
      advance    = hs && !out.last;
      finish     = hs && out.last;
      state_next = load ? S_WAIT : capture ? S_PRESENT : advance ? S_WAIT : finish ? S_IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out.valid <= 1'b0;
         out.index <= '0;
         out.data  <= '0;
         out.last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (capture) begin
            out.valid <= 1'b1;
            out.index <= a1;
            out.data  <= rd1;
            out.last  <= at_last;
         end else if (hs) begin
            out.valid <= 1'b0;
         end
         busy <= load ? 1'b1 : finish ? 1'b0 : busy;
         done <= finish;
      end
   end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: register-file model on read port 1 plus a scoreboard of
// expected {index, data, last} words checked at every stream handshake.
module tb_regfile_dump_reader;
   import regfile_dump_reader_pkg::*;
   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] data;
      logic        last;
   } word_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  first_idx = '0;
   logic [3:0]  last_idx = '0;
   logic [3:0]  a1;
   logic [31:0] rd1 = '0;
   logic        busy, done;
   logic [31:0] regs [NUM_REGS];
   word_t       q [$];
   int          checks = 0;
   int          failures = 0;
   regfile_dump_reader_if #(.ADDR_W(4), .DATA_W(32)) sif ();
   regfile_dump_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .first_idx (first_idx),
      .last_idx  (last_idx),
      .a1        (a1),
      .rd1       (rd1),
      .out       (sif),
      .busy      (busy),
      .done      (done)
   );
   always #5 clk = ~clk;
   // register file with a registered read port
   always @(posedge clk) rd1 <= regs[a1];

   task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input int stall_word,
                            input int stall_n, input int restart_cyc, output int words, output int dones);
      logic [3:0]  idx, h_idx, h_a1;
      logic [31:0] h_data;
      word_t       e;
      int          stall_left = 0, prev = -1, cyc = 0;
      bit          stalled = 0;
      words = 0;
      dones = 0;
      idx = f;
      q.push_back('{idx, regs[idx], idx == l});
      while (idx != l) begin
         idx = idx + 4'd1;
         q.push_back('{idx, regs[idx], idx == l});
      end
      first_idx = f;
      last_idx = l;
      sif.ready = 1'b1;
      start = 1'b1;
      while (dones == 0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_cyc);
         first_idx = ~f;
         last_idx = ~l;
         if (!sif.ready) begin
            checks++;
            if ({sif.valid, sif.index, sif.data, a1} !== {1'b1, h_idx, h_data, h_a1}) begin
               failures++;
               $display("FAIL stall_hold got=%h/%h/%h/%h exp=1/%h/%h/%h", sif.valid, sif.index, sif.data, a1, h_idx, h_data, h_a1);
            end
            stall_left--;
            if (stall_left == 0) sif.ready = 1'b1;
         end else if (sif.valid && words == stall_word && !stalled) begin
            stalled = 1;
            sif.ready = 1'b0;
            stall_left = stall_n;
            h_idx = sif.index;
            h_data = sif.data;
            h_a1 = a1;
         end
         if (sif.valid && sif.ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL extra_word got=%h/%h exp=none", sif.index, sif.data);
            end else begin
               e = q.pop_front();
               if ({sif.index, sif.data, sif.last} !== e) begin
                  failures++;
                  $display("FAIL word got=%h/%h/%b exp=%h/%h/%b", sif.index, sif.data, sif.last, e.idx, e.data, e.last);
               end
            end
            if (prev >= 0 && stall_n == 0) begin
               checks++;
               if (cyc - prev != 3) begin
                  failures++;
                  $display("FAIL spacing got=%0d exp=3", cyc - prev);
               end
            end
            prev = cyc;
            words++;
         end
         if (done) dones++;
      end
      start = 1'b0;
      sif.ready = 1'b1;
      checks++;
      if (dones == 0) begin
         failures++;
         $display("FAIL sweep_timeout got=no_done exp=done");
      end
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00) begin
         failures++;
         $display("FAIL done_pulse got=done%b busy%b exp=done0 busy0", done, busy);
      end
   endtask

   task automatic test_reset();
      sif.ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({a1, sif.valid, sif.index, sif.data, sif.last, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset got=%h/%b/%h/%h/%b/%b/%b exp=all0", a1, sif.valid, sif.index, sif.data, sif.last, busy, done);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_sweep();
      int w, d;
      run_sweep(4'd0, 4'd15, -1, 0, -1, w, d);
      checks++;
      if (w != 16 || d != 1 || q.size() != 0) begin
         failures++;
         $display("FAIL full_sweep got=words%0d dones%0d left%0d exp=16/1/0", w, d, q.size());
      end
   endtask

   task automatic test_wrap();
      int w, d;
      run_sweep(4'd14, 4'd1, -1, 0, -1, w, d);
      checks++;
      if (w != 4 || d != 1 || q.size() != 0) begin
         failures++;
         $display("FAIL wrap got=words%0d dones%0d left%0d exp=4/1/0", w, d, q.size());
      end
   endtask

   task automatic test_single();
      int w, d;
      regs[5] = 32'h0000_00A5;
      run_sweep(4'd5, 4'd5, -1, 0, -1, w, d);
      checks++;
      if (w != 1 || d != 1 || q.size() != 0) begin
         failures++;
         $display("FAIL single got=words%0d dones%0d left%0d exp=1/1/0", w, d, q.size());
      end
   endtask

   task automatic test_backpressure();
      int w, d;
      run_sweep(4'd0, 4'd3, 1, 10, -1, w, d);
      checks++;
      if (w != 4 || d != 1 || q.size() != 0) begin
         failures++;
         $display("FAIL backpressure got=words%0d dones%0d left%0d exp=4/1/0", w, d, q.size());
      end
   endtask

   task automatic test_restart_ignored();
      int w, d;
      run_sweep(4'd4, 4'd9, -1, 0, 5, w, d);
      checks++;
      if (w != 6 || d != 1 || q.size() != 0) begin
         failures++;
         $display("FAIL restart_ignored got=words%0d dones%0d left%0d exp=6/1/0", w, d, q.size());
      end
   endtask

   task automatic test_reset_mid_sweep();
      int w, d, cyc = 0;
      q.delete();
      first_idx = 4'd0;
      last_idx = 4'd3;
      sif.ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!sif.valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!sif.valid) begin
         failures++;
         $display("FAIL first_word_timeout got=valid0 exp=valid1");
      end
      @(negedge clk);
      checks++;
      if ({busy, sif.valid, a1} !== {1'b1, 1'b0, 4'd1}) begin
         failures++;
         $display("FAIL wait_word2 got=busy%b valid%b a1=%h exp=busy1 valid0 a1=1", busy, sif.valid, a1);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({a1, sif.valid, sif.index, sif.data, sif.last, busy, done} !== '0) begin
         failures++;
         $display("FAIL async_reset got=%h/%b/%h/%h/%b/%b/%b exp=all0", a1, sif.valid, sif.index, sif.data, sif.last, busy, done);
      end
      repeat (4) begin
         @(negedge clk);
         checks++;
         if ({done, busy, sif.valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_hold got=done%b busy%b valid%b exp=000", done, busy, sif.valid);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_sweep(4'd2, 4'd1, -1, 0, -1, w, d);
      checks++;
      if (w != 16 || d != 1 || q.size() != 0) begin
         failures++;
         $display("FAIL post_reset_sweep got=words%0d dones%0d left%0d exp=16/1/0", w, d, q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < PC_IDX; i++) regs[i] = 32'h1000_0000 + 32'(i);
      regs[PC_IDX] = 32'hDEAD_BEEF;
      test_reset();
      test_full_sweep();
      test_wrap();
      test_single();
      test_backpressure();
      test_restart_ignored();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
